dose_schedule_engine: RTL
=========================

# dose_schedule_engine

Parametrised multi-channel dose scheduler that replaces the single next-pill lookup in the prescription reminder datapath. It holds up to NUM_CHANNELS independent medication channels, each with a programmable dosing interval in hours. It counts each channel down on an external hour tick, raises per-channel alarms, tracks acknowledgements and missed doses, and reports which pill is due next and in how many hours. It sits between the clock block, which supplies the hour tick, and the seven-segment display path, which shows the ID and duration.

## Interface
- NUM_CHANNELS, 4: number of medication channels (1–16).
- HOUR_WIDTH, 5: width of interval, countdown and overdue counters.
- GRACE_HOURS, 2: hours an alarm may stay unacknowledged before it is logged as missed (1 to 2^HOUR_WIDTH−1).
- MISS_WIDTH, 4: width of the saturating missed-dose counter.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clears all state.
- hour_tick  in  1  single-cycle pulse, one per elapsed hour (demo or real rate is decided upstream).
- cfg_we  in  1  single-cycle configuration write strobe.
- cfg_channel  in  4  channel index written by cfg_we.
- cfg_interval  in  HOUR_WIDTH  dosing interval; 0 disables the channel.
- ack  in  1  single-cycle "dose taken" pulse from the shaped button.
- ack_channel  in  4  channel being acknowledged.
- alarm  out  NUM_CHANNELS  per-channel "dose due now".
- next_valid  out  1  at least one channel is enabled.
- next_id  out  4  channel index of the next or current dose.
- next_hours  out  HOUR_WIDTH  hours until next_id is due; 0 while an alarm is pending.
- missed_count  out  MISS_WIDTH  total missed doses, saturating.

## Operation
- Per-channel state: enabled, interval, count, alarm. count is the countdown while alarm=0 and the overdue-hour count while alarm=1.
- Config write to an in-range channel (cfg_channel < NUM_CHANNELS):
  - Stores the interval and sets enabled = (cfg_interval≠0).
  - Sets count = cfg_interval and clears alarm.
  - Out-of-range writes are ignored.
- On hour_tick, for each enabled channel:
  - alarm=0, count>1: decrement count.
  - alarm=0, count==1: count ← 0, alarm ← 1.
  - alarm=1, count+1 < GRACE_HOURS: increment count.
  - alarm=1, count+1 == GRACE_HOURS: clear alarm, count ← interval, increment missed_count (saturating at all-ones).
- ack on an enabled channel with alarm=1 clears alarm and sets count ← interval. ack on any other channel, or an out-of-range channel, is ignored.
- Priority per channel in the same cycle: reset > cfg_we > ack > hour_tick. The losing event has no effect on that channel. Other channels still process the tick.
- Next-dose selection:
  - If any alarm is set: next_id = lowest-index alarmed channel, next_hours = 0.
  - Otherwise: the enabled channel with minimum count; ties go to the lowest index. next_hours = that count.
  - If no channel is enabled: next_valid = 0 and next_id/next_hours = 0.
- Several channels may alarm on the same tick. Each alarm is independent; missed_count adds one per channel expiring on that tick, still saturating.

## Timing
- Reset values: alarm = 0, next_valid = 0, next_id = 0, next_hours = 0, missed_count = 0. All channels are disabled.
- Channel state updates on the clock edge that samples the event. alarm is visible 1 cycle after the tick, config write or ack.
- next_valid, next_id and next_hours are registered from the channel state, so latency is 2 cycles from the event.
- missed_count is visible 1 cycle after the expiring tick.
- Reset asserted mid-operation discards pending alarms and counts on that edge. There is no partial state.
- Back-to-back hour_tick pulses in consecutive cycles are legal and each one counts.

## Test plan
- Reset, then config ch0 interval 3 and ch2 interval 1 → next_valid=1, next_id=2, next_hours=1 two cycles later. One tick → alarm=4'b0100, next_hours=0.
- Ch1 interval 2; two ticks → alarm[1]=1. ack ch1 → alarm[1]=0, next_id=1, next_hours=2.
- GRACE_HOURS=2, ch3 interval 1 alarmed, no ack; two further ticks → alarm[3]=0, missed_count=1, ch3 count=1.
- ack and hour_tick in the same cycle on alarmed ch0 (interval 4) → alarm cleared, count=4, missed_count unchanged.
- Config ch0 interval 0, or cfg_channel=NUM_CHANNELS → ch0 disabled or write ignored. With all channels disabled → next_valid=0.
- Saturation: force 20 misses with MISS_WIDTH=4 → missed_count holds 15. Reset mid-alarm → every output returns to 0 on the next cycle.

Source files
------------

// File: rtl/dose_schedule_engine.sv
// dose_schedule_engine: multi-channel hour-tick dose countdown with alarms, grace-period miss logging
// and a registered next-dose selector for the display path.
module dose_schedule_engine #(
    parameter int NUM_CHANNELS = 4,
    parameter int HOUR_WIDTH   = 5,
    parameter int GRACE_HOURS  = 2,
    parameter int MISS_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hour_tick,
    input  logic                    cfg_we,
    input  logic [3:0]              cfg_channel,
    input  logic [HOUR_WIDTH-1:0]   cfg_interval,
    input  logic                    ack,
    input  logic [3:0]              ack_channel,
    output logic [NUM_CHANNELS-1:0] alarm,
    output logic                    next_valid,
    output logic [3:0]              next_id,
    output logic [HOUR_WIDTH-1:0]   next_hours,
    output logic [MISS_WIDTH-1:0]   missed_count
);
    localparam int N  = NUM_CHANNELS;
    localparam int W  = HOUR_WIDTH;
    localparam int SW = MISS_WIDTH + 5;
    localparam logic [W:0] GRACE = (W+1)'(GRACE_HOURS);

    logic [N-1:0]          en_q, en_d, alarm_q, alarm_d;
    logic [W-1:0]          interval_q [N];
    logic [W-1:0]          interval_d [N];
    logic [W-1:0]          count_q [N];
    logic [W-1:0]          count_d [N];
    logic [MISS_WIDTH-1:0] missed_q, missed_d;
    logic                  next_valid_q, next_valid_d, found;
    logic [3:0]            next_id_q, next_id_d;
    logic [W-1:0]          next_hours_q, next_hours_d;
    logic [4:0]            expire;
    logic [SW-1:0]         sum;

    always_comb begin
        en_d       = en_q;
        alarm_d    = alarm_q;
        interval_d = interval_q;
        count_d    = count_q;
        expire     = '0;
        for (int i = 0; i < N; i++) begin
            if (cfg_we && cfg_channel == 4'(i)) begin
                interval_d[i] = cfg_interval;
                en_d[i]       = |cfg_interval;
                count_d[i]    = cfg_interval;
                alarm_d[i]    = 1'b0;
            end else if (ack && ack_channel == 4'(i) && en_q[i] && alarm_q[i]) begin
                alarm_d[i] = 1'b0;
                count_d[i] = interval_q[i];
            end else if (hour_tick && en_q[i]) begin
                // while alarmed, count tracks hours overdue until the grace window closes
                if (!alarm_q[i]) begin
                    count_d[i] = (count_q[i] > W'(1)) ? count_q[i] - W'(1) : '0;
                    alarm_d[i] = (count_q[i] <= W'(1));
                end else if (({1'b0, count_q[i]} + (W+1)'(1)) < GRACE) begin
                    count_d[i] = count_q[i] + W'(1);
                end else begin
                    alarm_d[i] = 1'b0;
                    count_d[i] = interval_q[i];
                    expire     = expire + 5'd1;
                end
            end
        end
        sum      = SW'(missed_q) + SW'(expire);
        missed_d = (sum > SW'({MISS_WIDTH{1'b1}})) ? '1 : sum[MISS_WIDTH-1:0];
        next_valid_d = |en_q;
        next_id_d    = '0;
        next_hours_d = '0;
        found        = 1'b0;
        if (|alarm_q) begin
            for (int i = N - 1; i >= 0; i--)
                if (alarm_q[i]) next_id_d = 4'(i);
        end else begin
            for (int i = 0; i < N; i++)
                if (en_q[i] && (!found || count_q[i] < next_hours_d)) begin
                    found        = 1'b1;
                    next_id_d    = 4'(i);
                    next_hours_d = count_q[i];
                end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q         <= '0;
            alarm_q      <= '0;
            missed_q     <= '0;
            next_valid_q <= 1'b0;
            next_id_q    <= '0;
            next_hours_q <= '0;
            for (int i = 0; i < N; i++) begin
                interval_q[i] <= '0;
                count_q[i]    <= '0;
            end
        end else begin
            en_q         <= en_d;
            alarm_q      <= alarm_d;
            missed_q     <= missed_d;
            next_valid_q <= next_valid_d;
            next_id_q    <= next_id_d;
            next_hours_q <= next_hours_d;
            interval_q   <= interval_d;
            count_q      <= count_d;
        end
    end

    assign alarm        = alarm_q;
    assign next_valid   = next_valid_q;
    assign next_id      = next_id_q;
    assign next_hours   = next_hours_q;
    assign missed_count = missed_q;
endmodule
